i2c_sample_sched: RTL and testbench

//   Sequencer for the i2c_fsm temperature-read engine. Issues read requests from two sources:
//   a periodic timer and a manual request line, manual having priority. Drives fsm_start with

---
 rtl/i2c_sample_sched.sv | 178 +++++++++++++++++
 tb/tb_i2c_sample_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_sample_sched.sv
// i2c_sample_sched
//   Sequencer for the i2c_fsm temperature-read engine. It issues read requests
//   from two sources: a periodic timer and a manual request line. The manual
//   line has priority. fsm_start is held high until fsm_done arrives or the
//   transaction times out. A good result is captured into sample together with
//   a one-cycle sample_valid pulse.
//
//   Optional feature (macro I2C_SCHED_AVG_EN): sample_avg is the mean of every
//   group of 4 consecutive good samples. Without the macro, sample_avg and
//   avg_valid are tied to 0.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   en                   periodic sampling enable
//   req / req_ack        manual request (level, held) / 1-cycle accept pulse
//   fsm_start            start to i2c_fsm, held high for the whole transaction
//   fsm_done, fsm_msb,
//   fsm_lsb              completion and result from i2c_fsm
//   sample, sample_valid last good {msb,lsb} / update pulse
//   sample_src           source of the last accepted request (1 = manual)
//   timeout, err_cnt     abort pulse / saturating abort count
//   busy                 transaction in flight or inter-transaction gap
//   sample_avg, avg_valid  4-sample average / update pulse
module i2c_sample_sched #(
    parameter int PERIOD_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req,
    output logic        req_ack,
    output logic        fsm_start,
    input  logic        fsm_done,
    input  logic [7:0]  fsm_msb,
    input  logic [7:0]  fsm_lsb,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        sample_src,
    output logic        timeout,
    output logic [7:0]  err_cnt,
    output logic        busy,
    output logic [15:0] sample_avg,
    output logic        avg_valid
);
    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] tmr;
    logic          pend;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic          tick;
    logic          acc_man, acc_per, done_hit, to_hit;

    assign tick = en && (tmr == PW'(PERIOD_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        acc_man   = 1'b0;
        acc_per   = 1'b0;
        done_hit  = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                // rst gate keeps req_ack quiet during a reset cycle
                if (req && rst) begin
                    acc_man   = 1'b1;
                    state_nxt = BUSY;
                end else if (pend) begin
                    acc_per   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // done takes precedence over a coincident timeout
                if (fsm_done) begin
                    done_hit  = 1'b1;
                    state_nxt = GAP;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_hit    = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_CYCLES - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ack = acc_man;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            tmr          <= '0;
            pend         <= 1'b0;
            tcnt         <= '0;
            gcnt         <= '0;
            fsm_start    <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            sample_src   <= 1'b0;
            timeout      <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state <= state_nxt;

            // Timer runs in every state; a tick arriving while one is already
            // pending merges into it.
            if (!en) begin
                tmr  <= '0;
                pend <= 1'b0;
            end else begin
                tmr  <= tick ? '0 : tmr + 1'b1;
                pend <= tick | (pend & ~acc_per);
            end

            tcnt <= (state == BUSY && state_nxt == BUSY) ? tcnt + 1'b1 : '0;
            gcnt <= (state == GAP  && state_nxt == GAP)  ? gcnt + 1'b1 : '0;

            fsm_start    <= (state_nxt == BUSY);
            sample_valid <= done_hit;
            timeout      <= to_hit;

            if (done_hit)
                sample <= {fsm_msb, fsm_lsb};
            if (acc_man)
                sample_src <= 1'b1;
            else if (acc_per)
                sample_src <= 1'b0;
            if (to_hit && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef I2C_SCHED_AVG_EN
    logic [17:0] acc;
    logic [1:0]  acnt;
    logic [17:0] sum;

    assign sum = acc + {2'b00, fsm_msb, fsm_lsb};

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            acnt       <= '0;
            sample_avg <= '0;
            avg_valid  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (done_hit) begin
                if (acnt == 2'd3) begin
                    sample_avg <= sum[17:2];
                    avg_valid  <= 1'b1;
                    acc        <= '0;
                    acnt       <= '0;
                end else begin
                    acc  <= sum;
                    acnt <= acnt + 2'd1;
                end
            end
        end
    end
`else
    assign sample_avg = 16'h0000;
    assign avg_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_sample_sched.sv
module tb_i2c_sample_sched;
    localparam int P = 20, T = 30, G = 4;

    logic        clk = 1'b0;
    logic        rst, en, req, req_ack, fsm_start, fsm_done;
    logic [7:0]  fsm_msb, fsm_lsb, err_cnt;
    logic [15:0] sample, sample_avg;
    logic        sample_valid, sample_src, timeout, busy, avg_valid;

    always #5 clk = ~clk;

    i2c_sample_sched #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_ack(req_ack),
        .fsm_start(fsm_start), .fsm_done(fsm_done), .fsm_msb(fsm_msb), .fsm_lsb(fsm_lsb),
        .sample(sample), .sample_valid(sample_valid), .sample_src(sample_src),
        .timeout(timeout), .err_cnt(err_cnt), .busy(busy),
        .sample_avg(sample_avg), .avg_valid(avg_valid)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 transaction, 2 gap; ages are 1-based cycle counts.
    int m_mode, m_age, m_gap, m_tmr, m_err, m_sample, m_acc, m_n, m_avg;
    bit m_pend, m_src, m_sv, m_to, m_avgv, m_init = 0;

    task automatic step(input bit i_rst, input bit i_en, input bit i_req, input bit i_done,
                        input int d);
        bit took = 0, wrap;
        m_sv = 0; m_to = 0; m_avgv = 0;
        if (!i_rst) begin
            m_mode = 0; m_age = 0; m_gap = 0; m_tmr = 0; m_pend = 0; m_src = 0;
            m_err = 0; m_sample = 0; m_acc = 0; m_n = 0; m_avg = 0; m_init = 1;
            return;
        end
        case (m_mode)
            0: if (i_req) begin m_mode = 1; m_age = 0; m_src = 1; end
               else if (m_pend) begin took = 1; m_mode = 1; m_age = 0; m_src = 0; end
            1: begin
                m_age++;
                if (i_done) begin
                    m_sample = d; m_sv = 1; m_mode = 2; m_gap = G;
`ifdef I2C_SCHED_AVG_EN
                    m_acc += d; m_n++;
                    if (m_n == 4) begin m_avg = m_acc / 4; m_avgv = 1; m_acc = 0; m_n = 0; end
`endif
                end else if (m_age == T) begin
                    m_to = 1; if (m_err < 255) m_err++; m_mode = 2; m_gap = G;
                end
            end
            default: begin m_gap--; if (m_gap == 0) m_mode = 0; end
        endcase
        if (!i_en) begin m_tmr = 0; m_pend = 0; end
        else begin
            wrap = (m_tmr == P - 1);
            m_tmr = wrap ? 0 : m_tmr + 1;
            m_pend = wrap || (m_pend && !took);
        end
    endtask

    // Stimulus / i2c_fsm stand-in state
    bit s_rst, s_en, s_req, ack_drop, rand_lat, spur, align3;
    int lat_fix, lat, r_age;
    logic [15:0] d;

    task automatic cycle();
        bit dn, e_ack;
        @(negedge clk);
        if (!fsm_start) lat = rand_lat ? $urandom_range(1, 34) : lat_fix;
        r_age = fsm_start ? r_age + 1 : 0;
        dn = fsm_start && (r_age == lat);
        if (!fsm_start && spur && $urandom_range(0, 15) == 0) dn = 1;
        if (align3 && m_mode == 0 && m_tmr == P - 1 && s_en) begin s_req = 1; align3 = 0; end
        rst = s_rst; en = s_en; req = s_req;
        fsm_done = dn; fsm_msb = d[15:8]; fsm_lsb = d[7:0];
        #1;
        e_ack = s_rst && m_mode == 0 && s_req;
        if (m_init) begin
            chk("req_ack", req_ack, e_ack);
            chk("fsm_start", fsm_start, m_mode == 1);
            chk("busy", busy, m_mode != 0);
            chk("sample_valid", sample_valid, m_sv);
            chk("timeout", timeout, m_to);
            chk("sample", sample, m_sample);
            chk("sample_src", sample_src, m_src);
            chk("err_cnt", err_cnt, m_err);
            chk("sample_avg", sample_avg, m_avg);
            chk("avg_valid", avg_valid, m_avgv);
        end
        step(s_rst, s_en, s_req, dn, {16'h0, d});
        if (ack_drop && e_ack) s_req = 0;
    endtask

    initial begin
        s_rst = 0; s_en = 0; s_req = 0; ack_drop = 1; rand_lat = 0; spur = 0; align3 = 0;
        lat_fix = 10; lat = 10; r_age = 0; d = 16'h1A80;
        repeat (3) cycle();
        chk("rst_start", fsm_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_sample", sample, 0);
        s_rst = 1;

        // periodic sampling
        s_en = 1;
        repeat (120) cycle();
        chk("p1_sample", sample, 16'h1A80);
        chk("p1_src", sample_src, 0);

        // manual request with timer disabled
        s_en = 0;
        repeat (30) cycle();
        d = 16'h5501; s_req = 1;
        repeat (40) cycle();
        chk("p2_sample", sample, 16'h5501);
        chk("p2_src", sample_src, 1);

        // manual request on the same cycle as the timer wrap
        s_en = 1; align3 = 1;
        repeat (100) cycle();

        // timeouts and saturation
        s_en = 0; align3 = 0;
        repeat (30) cycle();
        lat_fix = 1000; s_req = 1;
        repeat (40) cycle();
        chk("p4_err1", err_cnt, 1);
        chk("p4_keep", sample, 16'h5501);
        ack_drop = 0; s_req = 1;
        repeat (260 * (T + G + 1)) cycle();
        chk("p4_err_sat", err_cnt, 8'hFF);
        s_req = 0; ack_drop = 1;
        repeat (10) cycle();

        // done on the timeout cycle wins
        d = 16'hABCD; lat_fix = T; s_req = 1;
        repeat (45) cycle();
        chk("p4_done_wins", sample, 16'hABCD);
        chk("p4_err_hold", err_cnt, 8'hFF);

        // reset mid-transaction
        lat_fix = 1000; s_req = 1;
        repeat (10) cycle();
        chk("p5_pre_start", fsm_start, 1);
        s_rst = 0; s_req = 0;
        cycle();
        s_rst = 1;
        cycle();
        chk("p5_start", fsm_start, 0);
        chk("p5_busy", busy, 0);
        chk("p5_err", err_cnt, 0);
        chk("p5_sv", sample_valid, 0);
        chk("p5_to", timeout, 0);

        // averaging over four samples
        lat_fix = 5;
        for (int k = 1; k <= 4; k++) begin
            d = 16'(k * 256); s_req = 1;
            repeat (20) cycle();
        end
`ifdef I2C_SCHED_AVG_EN
        chk("p6_avg", sample_avg, 16'h0280);
`else
        chk("p6_avg", sample_avg, 16'h0000);
`endif

        // randomized traffic
        rand_lat = 1; spur = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) s_en = !s_en;
            if (!s_req && $urandom_range(0, 9) == 0) s_req = 1;
            s_rst = ($urandom_range(0, 499) != 0);
            d = 16'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
